key_debouncer: RTL and testbench



---
 rtl/key_debouncer_pkg.sv | 26 ++
 rtl/key_debouncer_if.sv | 35 +++
 rtl/key_debouncer_cell.sv | 143 ++++++++++++++
 rtl/key_debouncer.sv | 45 ++++
 tb/tb_key_debouncer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/key_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants for the pushbutton debouncer. Defines the
//                active-low key levels, the default 50 MHz debounce and
//                auto-repeat periods, and a short debounce period that keeps
//                simulations fast.
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

    // Board pushbuttons are active-low.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // 10 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // 0.5 s auto-repeat period at 50 MHz.
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

    // Short debounce period for simulation.
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/key_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer_if
//  Description : Key bus between the raw pushbuttons and the command decoder.
//  Signals     : i_KEY      raw active-low buttons (asynchronous)
//                o_KEY      debounced active-low level
//                o_pressed  one-cycle strobe per accepted press
//                o_released one-cycle strobe per accepted release
//  Modports    : master drives the raw keys and observes the outputs;
//                slave is the debouncer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface key_debouncer_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] i_KEY;
    logic [NUM_KEYS-1:0] o_KEY;
    logic [NUM_KEYS-1:0] o_pressed;
    logic [NUM_KEYS-1:0] o_released;

    modport master (
        output i_KEY,
        input  o_KEY,
        input  o_pressed,
        input  o_released
    );

    modport slave (
        input  i_KEY,
        output o_KEY,
        output o_pressed,
        output o_released
    );
endinterface : key_debouncer_if
`default_nettype wire

// File: rtl/key_debouncer_cell.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_cell
//  Description : One key: 2-flop synchroniser, stability counter, debounced
//                level flop and registered press/release strobes. With
//                KEY_AUTOREPEAT_EN defined, a held key also produces extra
//                press strobes every REPEAT_CYCLES cycles.
//  Ports       : i_clk      system clock
//                i_reset    synchronous reset, active-high
//                i_key      raw active-low key (asynchronous)
//                o_key      debounced active-low level
//                o_pressed  one-cycle press (and repeat) strobe
//                o_released one-cycle release strobe
//  Macro       : KEY_AUTOREPEAT_EN enables the auto-repeat counter.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce_cell
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  wire logic i_clk,
    input  wire logic i_reset,
    input  wire logic i_key,
    output logic      o_key,
    output logic      o_pressed,
    output logic      o_released
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic             sync_meta_q;
    logic             sync_q;
    logic             stable_q,   stable_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             pressed_q,  pressed_d;
    logic             released_q, released_d;
    logic             w_accept;
    logic             w_repeat;

    // Synchroniser: the first flop is left free of logic so it only
    // resolves metastability.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_meta_q <= KEY_RELEASED;
            sync_q      <= KEY_RELEASED;
        end else begin
            sync_meta_q <= i_key;
            sync_q      <= sync_meta_q;
        end
    end

    // A differing level is accepted on the edge where the counter has
    // already seen DEBOUNCE_CYCLES-1 differing cycles, i.e. on the
    // DEBOUNCE_CYCLES-th consecutive differing sample.
    assign w_accept = (sync_q != stable_q) && (cnt_q == CNT_LAST);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (w_accept) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pressed_d  = (w_accept && (sync_q == KEY_PRESSED)) || w_repeat;
        released_d =  w_accept && (sync_q == KEY_RELEASED);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stable_q   <= KEY_RELEASED;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 1");
    end

    logic [RPT_W-1:0] rpt_q, rpt_d;

    // Counting starts on the edge after the press is accepted, so the first
    // repeat strobe lands exactly REPEAT_CYCLES cycles after the press
    // strobe. An accepting edge (the release) wins over a due repeat.
    always_comb begin
        rpt_d    = rpt_q;
        w_repeat = 1'b0;
        if (w_accept || (stable_q == KEY_RELEASED)) begin
            rpt_d = '0;
        end else if (rpt_q == RPT_LAST) begin
            rpt_d    = '0;
            w_repeat = 1'b1;
        end else begin
            rpt_d = rpt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    // REPEAT_CYCLES is only range-checked in this build.
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 1");
    end

    assign w_repeat = 1'b0;
`endif

    assign o_key      = stable_q;
    assign o_pressed  = pressed_q;
    assign o_released = released_q;

endmodule : key_debounce_cell
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Conditions NUM_KEYS raw active-low pushbuttons into a clean
//                level bus plus press/release strobes. Keys are handled by
//                fully independent cells; no priority or masking.
//  Ports       : i_clk    system clock
//                i_reset  synchronous reset, active-high
//                bus      key_debouncer_if slave (i_KEY, o_KEY, o_pressed,
//                         o_released)
//  Macro       : KEY_AUTOREPEAT_EN enables per-key auto-repeat strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    key_debouncer_if.slave bus
);

    if ((NUM_KEYS < 1) || (NUM_KEYS > 8)) begin : g_bad_num_keys
        $error("NUM_KEYS must be in 1..8");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_cell (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_key      (bus.i_KEY[k]),
            .o_key      (bus.o_KEY[k]),
            .o_pressed  (bus.o_pressed[k]),
            .o_released (bus.o_released[k])
        );
    end

endmodule : key_debouncer
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debouncer
//  Description : Self-checking bench for key_debouncer with NUM_KEYS=3,
//                DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8. Expected strobe
//                events (cycle, masks, level) are queued when stimulus is
//                driven and matched against observed strobes.
//  Macro       : KEY_AUTOREPEAT_EN selects the auto-repeat expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debouncer;
    import debounce_pkg::*;

    localparam int NK  = 3;
    localparam int DC  = SIM_DEBOUNCE_CYCLES;
    localparam int RC  = 8;
    localparam int LAT = DC + 2;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   passed;
    bit   mon_en;

    key_debouncer_if #(.NUM_KEYS(NK)) bus ();

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [NK-1:0] p;
        logic [NK-1:0] r;
        logic [NK-1:0] lvl;
    } ev_t;

    typedef struct {
        logic [NK-1:0] key;
        int            hold;
        logic [NK-1:0] p;
        logic [NK-1:0] r;
        logic [NK-1:0] lvl;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r,
                        input logic [NK-1:0] lvl);
        ev_t e;
        e.cyc = at; e.p = p; e.r = r; e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    // Scoreboard: overdue expectations are reported as missing; every
    // observed strobe must match the queue head exactly.
    always @(negedge clk) begin
        if (mon_en) begin
            while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
                ev_t m;
                m = exp_q.pop_front();
                total++;
                $display("FAIL missing_strobe: expected p=%b r=%b at cycle %0d, not observed by cycle %0d",
                         m.p, m.r, m.cyc, cyc);
            end
            if ((bus.o_pressed | bus.o_released) != '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_strobe: got p=%b r=%b at cycle %0d, expected none",
                             bus.o_pressed, bus.o_released, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("strobe_cycle",    cyc,            e.cyc);
                    chk("strobe_pressed",  bus.o_pressed,  e.p);
                    chk("strobe_released", bus.o_released, e.r);
                    chk("strobe_level",    bus.o_KEY,      e.lvl);
                end
            end
        end
    end

    initial begin
        total  = 0;
        passed = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.i_KEY = 3'b111;

        // key, hold, pressed, released, level at end of hold
        vecs[0]  = '{3'b111, 20, 3'b000, 3'b000, 3'b111};
        vecs[1]  = '{3'b110, 10, 3'b001, 3'b000, 3'b110};
        vecs[2]  = '{3'b111, 10, 3'b000, 3'b001, 3'b111};
        vecs[3]  = '{3'b101,  3, 3'b000, 3'b000, 3'b111};
        vecs[4]  = '{3'b111,  1, 3'b000, 3'b000, 3'b111};
        vecs[5]  = '{3'b101,  3, 3'b000, 3'b000, 3'b111};
        vecs[6]  = '{3'b111,  1, 3'b000, 3'b000, 3'b111};
        vecs[7]  = '{3'b101, 10, 3'b010, 3'b000, 3'b101};
        vecs[8]  = '{3'b111, 10, 3'b000, 3'b010, 3'b111};
        vecs[9]  = '{3'b010, 10, 3'b101, 3'b000, 3'b010};
        vecs[10] = '{3'b111, 10, 3'b000, 3'b101, 3'b111};

        repeat (3) tick();
        chk("reset_o_KEY",      bus.o_KEY,      3'b111);
        chk("reset_o_pressed",  bus.o_pressed,  3'b000);
        chk("reset_o_released", bus.o_released, 3'b000);
        mon_en = 1'b1;
        rst    = 1'b0;

        for (int i = 0; i < 11; i++) begin
            bus.i_KEY = vecs[i].key;
            if ((vecs[i].p | vecs[i].r) != '0)
                push(cyc + LAT, vecs[i].p, vecs[i].r, vecs[i].lvl);
            repeat (vecs[i].hold) tick();
            chk($sformatf("vec%0d_level", i), bus.o_KEY, vecs[i].lvl);
        end

        // Reset while key 1 is mid-count (counter at 2): no strobe, level
        // stays released; a fresh press follows full latency after reset.
        bus.i_KEY = 3'b101;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("midreset_o_KEY", bus.o_KEY, 3'b111);
        rst = 1'b0;
        push(cyc + LAT, 3'b010, 3'b000, 3'b101);
        repeat (10) tick();
        chk("postreset_level", bus.o_KEY, 3'b101);
        bus.i_KEY = 3'b111;
        push(cyc + LAT, 3'b000, 3'b010, 3'b111);
        repeat (10) tick();
        chk("postreset_release_level", bus.o_KEY, 3'b111);

        // Long hold of key 0: release is accepted 30 cycles after the press.
        bus.i_KEY = 3'b110;
        begin
            int a;
            a = cyc + LAT;
            push(a, 3'b001, 3'b000, 3'b110);
`ifdef KEY_AUTOREPEAT_EN
            for (int k = 1; RC * k < 30; k++)
                push(a + RC * k, 3'b001, 3'b000, 3'b110);
`endif
        end
        repeat (30) tick();
        chk("hold_level", bus.o_KEY, 3'b110);
        bus.i_KEY = 3'b111;
        push(cyc + LAT, 3'b000, 3'b001, 3'b111);
        repeat (10) tick();
        chk("hold_release_level", bus.o_KEY, 3'b111);

        repeat (20) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_key_debouncer
`default_nettype wire
